// File: rtl/pal_pkg.sv
// Shared definitions for the palindrome range scanner and the analyzer top-level wiring.
package pal_pkg;

  localparam int PAL_WIDTH   = 32;
  localparam int PAL_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RECORD,
    ST_NEXT,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/pal_scan_watchdog.sv
// Down-counter guarding one number's RUN phase; expired flags the final allowed RUN cycle.
module pal_scan_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT);
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == CW'(1));

endmodule

// File: rtl/pal_range_scanner.sv
// Walks an inclusive unsigned range, feeding each number to pal_number_analyzer and tallying palindromes.
// Optional RUN watchdog compiled in with PAL_SCAN_TIMEOUT_EN.
module pal_range_scanner
  import pal_pkg::*;
#(
  parameter int WIDTH   = PAL_WIDTH,
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = PAL_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   range_lo,
  input  logic [WIDTH-1:0]   range_hi,
  output logic [WIDTH-1:0]   ana_number,
  output logic               ana_enable,
  input  logic               ana_ready,
  input  logic               ana_is_pal,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pal_count,
  output logic [WIDTH-1:0]   last_pal,
  output logic               error
);

  scan_state_t        state, state_next;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   hi_q;
  logic               run_first;
  logic               ready_ok;
  logic               wd_fire;

  // The analyzer was just held in reset by LOAD, so a ready seen on the first RUN cycle is stale.
  assign ready_ok = ana_ready && !run_first;

`ifdef PAL_SCAN_TIMEOUT_EN
  logic wd_expired;
  logic error_q;

  pal_scan_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .load    (state == ST_LOAD),
    .tick    (state == ST_RUN),
    .expired (wd_expired)
  );

  assign wd_fire = (state == ST_RUN) && !ready_ok && wd_expired;
  assign error   = error_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
      error_q <= 1'b0;
    end else if (wd_fire) begin
      error_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (range_lo > range_hi) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD:   state_next = ST_RUN;
      ST_RUN: begin
        if (ready_ok)     state_next = ST_RECORD;
        else if (wd_fire) state_next = ST_DONE;
      end
      ST_RECORD: state_next = ST_NEXT;
      ST_NEXT:   state_next = (cur == hi_q) ? ST_DONE : ST_LOAD;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur       <= '0;
      hi_q      <= '0;
      run_first <= 1'b0;
      pal_count <= '0;
      last_pal  <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cur       <= range_lo;
            hi_q      <= range_hi;
            pal_count <= '0;
            last_pal  <= '0;
          end
        end
        ST_LOAD: run_first <= 1'b1;
        ST_RUN:  run_first <= 1'b0;
        ST_RECORD: begin
          if (ana_is_pal) begin
            if (pal_count != '1) pal_count <= pal_count + 1'b1;
            last_pal <= cur;
          end
        end
        // Compare before incrementing so an all-ones upper bound terminates cleanly.
        ST_NEXT: begin
          if (cur != hi_q) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ana_number = cur;
  assign ana_enable = (state == ST_RUN);
  assign busy       = (state == ST_LOAD) || (state == ST_RUN) ||
                      (state == ST_RECORD) || (state == ST_NEXT);
  assign done       = (state == ST_DONE);

endmodule

// File: doc/pal_range_scanner.md
# pal_range_scanner

Sequencer directly upstream of `pal_number_analyzer`. It walks an inclusive unsigned range of 32-bit numbers and presents each one to the analyzer. For each number it drives the analyzer's `in_number`/`enable`, waits for `out_ready`, samples `is_pal`, and accumulates a palindrome count plus the most recent palindrome found. Results go to the host/top level as a done-held summary.

## Interface
Parameters:
- `WIDTH`, 32, data width of range bounds and analyzer number.
- `COUNT_W`, 16, width of the palindrome counter.
- `TIMEOUT`, 64, maximum RUN cycles per number before the watchdog fires. Only used when the watchdog is compiled in.

Ports:
- `clock`  input  1  single clock, rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle request. Accepted only in IDLE or DONE.
- `range_lo`  input  WIDTH  first number, sampled on accepted `start`.
- `range_hi`  input  WIDTH  last number (inclusive), sampled on accepted `start`.
- `ana_number`  output  WIDTH  to analyzer `in_number`.
- `ana_enable`  output  1  to analyzer `enable`.
- `ana_ready`  input  1  from analyzer `out_ready`.
- `ana_is_pal`  input  1  from analyzer `is_pal`.
- `busy`  output  1  high from the cycle after accept until DONE entry.
- `done`  output  1  held high in DONE.
- `pal_count`  output  COUNT_W  palindromes found, saturating.
- `last_pal`  output  WIDTH  most recent palindrome; 0 if none.
- `error`  output  1  watchdog fired during this scan.

## Operation
States: IDLE, LOAD, RUN, RECORD, NEXT, DONE.
- **IDLE/DONE, on `start`:**
  - Latch `lo`/`hi`. Clear `pal_count`, `last_pal`, `error`.
  - If `lo > hi` (unsigned): go to DONE. The analyzer is never enabled.
  - Otherwise set `cur = lo` and go to LOAD.
- **LOAD** (1 cycle): `ana_number = cur`, `ana_enable = 0`. This forces the analyzer to its initial state so it reloads the number.
- **RUN:** `ana_enable = 1`, `ana_number` held at `cur`.
  - On `ana_ready = 1`: go to RECORD.
- **RECORD** (1 cycle): sample `ana_is_pal`.
  - If 1: `pal_count` increments (saturating at all-ones) and `last_pal = cur`.
  - `ana_enable` drops to 0.
- **NEXT** (1 cycle):
  - If `cur == hi`: go to DONE.
  - Otherwise `cur = cur + 1` and go to LOAD.
  - The comparison happens before the increment, so `hi = 2^WIDTH-1` never wraps.
- **DONE:** `done = 1`; the summary outputs hold. A new `start` restarts the scan.

Other rules:
- `start` in any other state is ignored.
- `ana_number` is driven combinationally from `cur`. `ana_enable` is registered-state decoded and high only in RUN.
- Values with bit `WIDTH-1` set are passed through unchanged. The analyzer's verdict is recorded verbatim.

## Timing
- **Reset (`reset = 0` at a rising edge):**
  - State returns to IDLE.
  - `ana_enable`, `busy`, `done`, `error` = 0.
  - `pal_count`, `last_pal`, `ana_number` = 0.
  - Reset mid-scan abandons the scan and leaves no partial `done`.
- **Start:** accepted at edge *t*. LOAD occupies cycle *t+1*; `ana_enable` first rises in cycle *t+2*.
- **Per number:** 3 overhead cycles (LOAD, RECORD, NEXT) plus RUN cycles up to and including the one where `ana_ready` is sampled high.
- **Outputs:** `pal_count`/`last_pal` update at the edge leaving RECORD. `done` rises the cycle after the final NEXT.
- **Empty range (`lo > hi`):** `done` is high in cycle *t+1*, with `pal_count = 0`.
- **`ana_ready` already high on RUN entry:** not trusted. RUN ignores `ana_ready` in its first cycle, because the analyzer was held in its initial state by LOAD.

## Configuration
- `PAL_SCAN_TIMEOUT_EN` defined:
  - A RUN-cycle counter is compiled in and resets on LOAD.
  - When the counter reaches `TIMEOUT` without `ana_ready`, `error = 1`, `ana_enable` drops, and the FSM goes to DONE. Counts gathered so far are kept.
- Undefined: no counter; `error` is tied to 0; RUN waits indefinitely.

## Structure
- **Shared package `pal_pkg`:** scanner state enum, the default `WIDTH`, and the `TIMEOUT` constant. Both the scanner and the analyzer top-level wiring use it.
- **Sub-module `pal_scan_watchdog`:**
  - Purpose: down-counter with `load`/`tick`/`expired`.
  - Only instantiated under `PAL_SCAN_TIMEOUT_EN`.
- **Unit verification:** the analyzer is not instantiated inside the scanner. The bench connects a real analyzer instance or a stub.

## Test plan
- Range 10..22 with real analyzer -> `pal_count = 2`, `last_pal = 22`, `done = 1`, `error = 0`.
- Range 0..9 -> `pal_count = 10`, `last_pal = 9`. Range 121..121 -> `pal_count = 1`, `last_pal = 121`.
- `lo = 5`, `hi = 3` -> `done` high one cycle after `start`, `pal_count = 0`, `ana_enable` never high.
- Stub that never asserts `ready`, with macro defined, range 7..9 -> `error = 1` after 64 RUN cycles on number 7, `done = 1`, `pal_count = 0`. Without the macro, the FSM stays in RUN.
- Range 100..200, `reset` low during the third RUN -> next cycle all outputs are 0 and the state is IDLE. `start` pulses while `busy` are ignored; the scan completes with `pal_count = 10`.
- Stub returning `is_pal = 1` for every number, `COUNT_W = 2`, range 0..6 -> `pal_count` saturates at 3, `last_pal = 6`.
